// File: rtl/uart_tx_cts.sv
// Buffered 8N1 UART transmitter with a small byte FIFO and active-low CTS gating of frame starts.
// tx, in_ready, busy and fifo_count are all driven straight from flops.
module uart_tx_cts #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          cts,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [BAUD_W-1:0]  baud_r;
    logic [BAUD_W-1:0]  baud_s;
    logic [2:0]         bit_r;
    logic [2:0]         bit_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_s;
    logic               tx_r;
    logic               tx_s;
    logic               pop_s;
    logic               push_s;
    logic               baud_done_s;

    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               in_ready_r;
    logic               busy_r;

    assign push_s      = in_valid & in_ready_r;
    assign baud_done_s = (baud_r == BAUD_LAST);

    assign in_ready   = in_ready_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // Frame sequencer; tx is computed from the next state so the line moves on the same edge as the FSM
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        tx_s    = 1'b1;
        case (state_r)
            IDLE: begin
                // CTS is only consulted here, so a frame already started always completes
                if ((count_r != {CNT_W{1'b0}}) && (cts == 1'b0)) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    state_s = START;
                    baud_s  = {BAUD_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_done_s) begin
                    state_s = DATA;
                    baud_s  = {BAUD_W{1'b0}};
                    bit_s   = 3'd0;
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    baud_s  = {BAUD_W{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                        bit_s   = 3'd0;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_r == STOP_LAST) begin
                        state_s = IDLE;
                        bit_s   = 3'd0;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = {BAUD_W{1'b0}};
                bit_s   = 3'd0;
            end
        endcase

        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State, counters, FIFO pointers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_r      <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_r     <= baud_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            count_r    <= count_s;
            in_ready_r <= (count_s != DEPTH_C);
            busy_r     <= (state_s != IDLE) || (count_s != {CNT_W{1'b0}});
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_cts.sv
// Scoreboard bench for uart_tx_cts: bytes accepted are queued, and a line monitor
// decodes each frame on tx bit-exactly and compares it with the queue head.
module tb_uart_tx_cts;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int SB    = 1;
    localparam int FRAME = (9 + SB) * CPB;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int GAP   = FRAME + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          cts = 1'b1;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frames_done = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    uart_tx_cts #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cts        (cts),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: one sample per cycle, a frame is FRAME samples starting at the falling edge
    initial begin : monitor
        bit                 active;
        int                 n;
        logic [FRAME-1:0]   got;
        logic [FRAME-1:0]   want;
        logic [9:0]         fr;
        logic [7:0]         b;
        active = 1'b0;
        n = 0;
        got = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    got[0] = tx;
                    n = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                got[n] = tx;
                n++;
                if (n == FRAME) begin
                    active = 1'b0;
                    frames_done++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got bits %h, no byte was queued", got);
                    end else begin
                        b = exp_q.pop_front();
                        fr = {1'b1, b, 1'b0};
                        for (int i = 0; i < FRAME; i++) want[i] = fr[i / CPB];
                        if (got !== want) begin
                            errors++;
                            $display("FAIL frame_bits: got %h, expected %h (byte %h)", got, want, b);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] b, output bit acc);
        in_data  = b;
        in_valid = 1'b1;
        acc      = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames_done < n) begin
            errors++;
            $display("FAIL %s_frames: got %0d frames, expected %0d", tag, frames_done, n);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin
            step();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b, expected 0", busy);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({tx, in_ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL reset_values: tx=%b in_ready=%b busy=%b count=%0d, expected 1 1 0 0",
                     tx, in_ready, busy, fifo_count);
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({tx, in_ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL post_reset: tx=%b in_ready=%b busy=%b count=%0d, expected 1 1 0 0",
                     tx, in_ready, busy, fifo_count);
        end
        step();
    endtask

    task automatic test_single();
        bit acc;
        int n0;
        n0 = frames_done;
        cts = 1'b0;
        do_push(8'hA5, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b, expected 1", acc); end
        @(negedge clk);
        checks++;
        if ({fifo_count, busy, tx} !== {CW'(1), 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_queued: count=%0d busy=%b tx=%b, expected 1 1 1", fifo_count, busy, tx);
        end
        @(negedge clk);
        checks++;
        if ({fifo_count, tx} !== {CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL single_start: count=%0d tx=%b, expected 0 0", fifo_count, tx);
        end
        repeat (FRAME - 1) @(negedge clk);
        checks++;
        if ({busy, tx} !== 2'b11) begin
            errors++;
            $display("FAIL single_last_stop: busy=%b tx=%b, expected 1 1", busy, tx);
        end
        @(negedge clk);
        checks++;
        if ({busy, tx} !== 2'b01) begin
            errors++;
            $display("FAIL single_busy_drop: busy=%b tx=%b, expected 0 1", busy, tx);
        end
        wait_frames(n0 + 1, 100, "single");
        step();
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n0;
        int peak;
        int prev;
        bit rose;
        wait_idle();
        start_q.delete();
        n0 = frames_done;
        cts = 1'b0;
        do_push(8'h00, acc);
        do_push(8'hFF, acc);
        do_push(8'h55, acc);
        @(negedge clk);
        // first byte leaves on the second push edge, so occupancy peaks at 2
        checks++;
        if (fifo_count !== CW'(2)) begin
            errors++;
            $display("FAIL b2b_count_after_pushes: got %0d, expected 2", fifo_count);
        end
        peak = 2;
        prev = 2;
        rose = 1'b0;
        for (int k = 0; k < 400 && frames_done < n0 + 3; k++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (int'(fifo_count) > prev) rose = 1'b1;
            prev = int'(fifo_count);
        end
        checks++;
        if (peak != 2 || rose) begin
            errors++;
            $display("FAIL b2b_count_profile: peak=%0d rose=%b, expected peak 2 and non-increasing", peak, rose);
        end
        wait_frames(n0 + 3, 10, "b2b");
        checks++;
        if (start_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_starts: got %0d starts, expected 3", start_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (start_q[i] - start_q[i-1] != GAP) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got %0d cycles, expected %0d", i, start_q[i] - start_q[i-1], GAP);
                end
            end
        end
    endtask

    task automatic test_full();
        bit acc [5];
        logic [7:0] bytes [5];
        int n0;
        wait_idle();
        n0 = frames_done;
        bytes[0] = 8'h81; bytes[1] = 8'h42; bytes[2] = 8'h24; bytes[3] = 8'h18; bytes[4] = 8'hE7;
        cts = 1'b1;
        for (int i = 0; i < 5; i++) do_push(bytes[i], acc[i]);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc[i] !== (i < 4)) begin
                errors++;
                $display("FAIL full_accept%0d: got %b, expected %b", i, acc[i], (i < 4));
            end
        end
        @(negedge clk);
        checks++;
        if ({fifo_count, in_ready, busy} !== {CW'(4), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL full_status: count=%0d in_ready=%b busy=%b, expected 4 0 1", fifo_count, in_ready, busy);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL full_hold_tx: got %b, expected 1", tx); end
        end
        step();
        cts = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, fifo_count} !== {1'b0, CW'(4)}) begin
            errors++;
            $display("FAIL full_before_pop: in_ready=%b count=%0d, expected 0 4", in_ready, fifo_count);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, fifo_count, tx} !== {1'b1, CW'(3), 1'b0}) begin
            errors++;
            $display("FAIL full_after_pop: in_ready=%b count=%0d tx=%b, expected 1 3 0", in_ready, fifo_count, tx);
        end
        wait_frames(n0 + 4, 400, "full");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: %0d bytes left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_cts_mid();
        bit acc;
        int n0;
        wait_idle();
        n0 = frames_done;
        cts = 1'b0;
        do_push(8'h3C, acc);
        repeat (10) step();
        cts = 1'b1;
        do_push(8'hC3, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL cts_accept: got %b, expected 1", acc); end
        wait_frames(n0 + 1, 100, "cts_first");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy} !== 2'b11) begin
                errors++;
                $display("FAIL cts_hold: tx=%b busy=%b, expected 1 1", tx, busy);
            end
        end
        checks++;
        if (fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL cts_hold_count: got %0d, expected 1", fifo_count);
        end
        step();
        cts = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL cts_release_same: tx=%b, expected 1", tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL cts_release_start: tx=%b, expected 0", tx); end
        wait_frames(n0 + 2, 100, "cts_second");
    endtask

    task automatic test_reset_mid();
        bit acc;
        int n0;
        wait_idle();
        n0 = frames_done;
        cts = 1'b0;
        do_push(8'hA5, acc);
        do_push(8'h77, acc);
        repeat (17) step();
        #1;
        checks++;
        if ({tx, fifo_count} !== {1'b0, CW'(1)}) begin
            errors++;
            $display("FAIL rst_pre_bit3: tx=%b count=%0d, expected 0 1", tx, fifo_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tx, fifo_count, busy, in_ready} !== {1'b1, CW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_async: tx=%b count=%0d busy=%b in_ready=%b, expected 1 0 0 1",
                     tx, fifo_count, busy, in_ready);
        end
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if ({tx, fifo_count, busy} !== {1'b1, CW'(0), 1'b0}) begin
                errors++;
                $display("FAIL rst_residual: tx=%b count=%0d busy=%b, expected 1 0 0", tx, fifo_count, busy);
            end
        end
        checks++;
        if (frames_done != n0) begin
            errors++;
            $display("FAIL rst_frames: got %0d, expected %0d", frames_done, n0);
        end
        step();
    endtask

    task automatic test_simul();
        bit acc;
        int n0;
        wait_idle();
        start_q.delete();
        n0 = frames_done;
        cts = 1'b1;
        do_push(8'h6B, acc);
        @(negedge clk);
        checks++;
        if ({fifo_count, tx} !== {CW'(1), 1'b1}) begin
            errors++;
            $display("FAIL simul_pre: count=%0d tx=%b, expected 1 1", fifo_count, tx);
        end
        step();
        cts = 1'b0;
        do_push(8'h9D, acc);
        @(negedge clk);
        checks++;
        if ({acc, fifo_count, tx} !== {1'b1, CW'(1), 1'b0}) begin
            errors++;
            $display("FAIL simul_pushpop: acc=%b count=%0d tx=%b, expected 1 1 0", acc, fifo_count, tx);
        end
        wait_frames(n0 + 2, 200, "simul");
        checks++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != GAP) begin
            errors++;
            $display("FAIL simul_gap: starts=%0d, expected 2 starts %0d apart", start_q.size(), GAP);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_cts_mid();
        test_reset_mid();
        test_simul();
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d bytes never sent", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
